// File: rtl/servo_pkg.sv
// Shared definitions for the servo array controller: command word geometry,
// field offsets inside the command word, and mode / decode constants.
package servo_pkg;

   // Mode field values inside the command word
   localparam logic MODE_MAINT = 1'b1;
   localparam logic MODE_RUN   = 1'b0;

   // Classification of a completed command word
   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_BAD   = 3'd1,
      CMD_CLEAR = 3'd2,
      CMD_MAINT = 3'd3,
      CMD_RUN   = 3'd4
   } cmd_kind_e;

   // Command word length: active + mode + channel index + position
   function automatic int cmd_w(input int ch_w, input int pos_w);
      return 2 + ch_w + pos_w;
   endfunction

   // Bit offsets, MSB->LSB: active, mode, chan[ch_w], pos[pos_w]
   function automatic int act_bit(input int ch_w, input int pos_w);
      return cmd_w(ch_w, pos_w) - 1;
   endfunction

   function automatic int mode_bit(input int ch_w, input int pos_w);
      return cmd_w(ch_w, pos_w) - 2;
   endfunction

   function automatic int ch_lsb(input int pos_w);
      return pos_w;
   endfunction

   function automatic int pos_lsb();
      return 0;
   endfunction

endpackage

// File: rtl/servo_array_ctrl_if.sv
// Bus between the mbed-facing serial link / servo headers and the controller.
// The master side drives the serial strobe and data; the slave side is the
// controller that produces the PWM and status outputs.
interface servo_array_ctrl_if #(
   parameter int N_CH = 4
);
   logic            set_bit;
   logic            input_bit;
   logic [N_CH-1:0] servo_pulse;
   logic [N_CH-1:0] chan_en;
   logic            maint_mode;
   logic            cmd_ready;
   logic            cmd_err;
   logic            frame_tick;

   modport master (
      output set_bit,
      output input_bit,
      input  servo_pulse,
      input  chan_en,
      input  maint_mode,
      input  cmd_ready,
      input  cmd_err,
      input  frame_tick
   );

   modport slave (
      input  set_bit,
      input  input_bit,
      output servo_pulse,
      output chan_en,
      output maint_mode,
      output cmd_ready,
      output cmd_err,
      output frame_tick
   );
endinterface

// File: rtl/servo_pwm_channel.sv
// One servo PWM channel: position target, current position (optionally
// slewed), frame-boundary shadow latch, width comparator and output flop.
// Optional feature macro: SERVO_SLEW_EN (current position steps 1 LSB per
// frame toward the target instead of jumping).
module servo_pwm_channel #(
   parameter int POS_W    = 8,
   parameter int CNT_W    = 20,
   parameter int MIN_CYC  = 50_000,
   parameter int STEP_CYC = 196
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             boundary,   // period counter == 0 this cycle
   input  logic [CNT_W-1:0] cnt,
   input  logic             wr_en,      // decoded command writes this target
   input  logic [POS_W-1:0] wr_pos,
   input  logic             pend_en,    // pending enable including this cycle's command
   output logic             pulse,
   output logic             en
);

   localparam logic [POS_W-1:0] POS_MID = {1'b1, {(POS_W-1){1'b0}}};

   logic [POS_W-1:0] target_r;
   logic [POS_W-1:0] target_nxt_s;
   logic [POS_W-1:0] cur_pos_s;
   logic [POS_W-1:0] shadow_r;
   logic [POS_W-1:0] eff_pos_s;
   logic             eff_en_s;
   logic             en_r;
   logic             pulse_r;
   logic [63:0]      thr_s;

   // Next target: a write in this cycle is visible at a coincident boundary
   always_comb begin
      target_nxt_s = target_r;
      if (wr_en) begin
         target_nxt_s = wr_pos;
      end else begin
         target_nxt_s = target_r;
      end
   end

   // Target register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target_r <= POS_MID;
      end else begin
         target_r <= target_nxt_s;
      end
   end

`ifdef SERVO_SLEW_EN
   logic [POS_W-1:0] cur_pos_r;

   // Step the current position one LSB toward the target at each boundary
   always_comb begin
      cur_pos_s = cur_pos_r;
      if (boundary && (cur_pos_r < target_nxt_s)) begin
         cur_pos_s = cur_pos_r + POS_W'(1);
      end else if (boundary && (cur_pos_r > target_nxt_s)) begin
         cur_pos_s = cur_pos_r - POS_W'(1);
      end else begin
         cur_pos_s = cur_pos_r;
      end
   end

   // Current position register for the slewed path
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_pos_r <= POS_MID;
      end else begin
         cur_pos_r <= cur_pos_s;
      end
   end
`else
   // Without slew the current position follows the target directly
   always_comb begin
      cur_pos_s = target_nxt_s;
   end
`endif

   // Values used this cycle: at the boundary the freshly latched ones apply,
   // otherwise the frame-latched ones, so a frame's pulse never changes mid-way
   always_comb begin
      eff_pos_s = shadow_r;
      eff_en_s  = en_r;
      if (boundary) begin
         eff_pos_s = cur_pos_s;
         eff_en_s  = pend_en;
      end else begin
         eff_pos_s = shadow_r;
         eff_en_s  = en_r;
      end
      thr_s = 64'(MIN_CYC) + (64'(eff_pos_s) * 64'(STEP_CYC));
   end

   // Frame latch and registered PWM comparator output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_r <= POS_MID;
         en_r     <= 1'b0;
         pulse_r  <= 1'b0;
      end else begin
         shadow_r <= eff_pos_s;
         en_r     <= eff_en_s;
         pulse_r  <= eff_en_s && (64'(cnt) < thr_s);
      end
   end

   assign pulse = pulse_r;
   assign en    = en_r;

endmodule

// File: rtl/servo_array_ctrl.sv
// Multi-channel servo controller top: synchronises the mbed serial link,
// deserialises and decodes command words, keeps the pending enable set and
// the shared PWM period counter, and drives N_CH servo_pwm_channel slices.
// Optional feature macro: SERVO_SLEW_EN (handled inside servo_pwm_channel).
module servo_array_ctrl
   import servo_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CH_W        = 2,
   parameter int POS_W       = 8,
   parameter int PERIOD_CYC  = 1_000_000,
   parameter int MIN_CYC     = 50_000,
   parameter int STEP_CYC    = 196,
   parameter int TIMEOUT_CYC = 500_000
) (
   input  logic               clk,
   input  logic               reset,
   servo_array_ctrl_if.slave  bus
);

   localparam int CMD_W    = cmd_w(CH_W, POS_W);
   localparam int ACT_BIT  = act_bit(CH_W, POS_W);
   localparam int MODE_BIT = mode_bit(CH_W, POS_W);
   localparam int CH_LSB   = ch_lsb(POS_W);
   localparam int POS_LSB  = pos_lsb();
   localparam int CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int BIT_W    = $clog2(CMD_W + 1);
   localparam int IDLE_W   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CMD_W - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   // Synchroniser and edge detect
   logic set_meta_r, set_sync_r, set_prev_r;
   logic din_meta_r, din_sync_r;
   logic set_rise_s;

   // Deserialiser
   logic [CMD_W-1:0]  shift_r;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [IDLE_W-1:0] idle_cnt_r;
   logic              word_valid_r;
   logic              timeout_s;

   // Decode
   logic              act_s;
   logic              mode_s;
   logic [CH_W-1:0]   chan_s;
   logic [POS_W-1:0]  pos_s;
   logic [N_CH-1:0]   onehot_s;
   cmd_kind_e         kind_s;
   logic [N_CH-1:0]   pend_nxt_s;
   logic [N_CH-1:0]   wr_en_s;
   logic              maint_nxt_s;

   // Command state and status
   logic [N_CH-1:0]   pend_en_r;
   logic              maint_mode_r;
   logic              cmd_ready_r;
   logic              cmd_err_r;

   // PWM timebase
   logic [CNT_W-1:0]  cnt_r;
   logic              boundary_s;
   logic              frame_tick_r;
   logic [N_CH-1:0]   pulse_s;
   logic [N_CH-1:0]   en_s;

   // Two-flop synchronisers for the asynchronous strobe and data, plus edge history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         set_meta_r <= 1'b0;
         set_sync_r <= 1'b0;
         set_prev_r <= 1'b0;
         din_meta_r <= 1'b0;
         din_sync_r <= 1'b0;
      end else begin
         set_meta_r <= bus.set_bit;
         set_sync_r <= set_meta_r;
         set_prev_r <= set_sync_r;
         din_meta_r <= bus.input_bit;
         din_sync_r <= din_meta_r;
      end
   end

   assign set_rise_s = set_sync_r & ~set_prev_r;

   // A partial word that sees no strobe for TIMEOUT_CYC cycles is abandoned
   assign timeout_s = (bit_cnt_r != '0) && !set_rise_s && (idle_cnt_r == IDLE_LAST);

   // Shift register, bit counter and idle timer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_r      <= '0;
         bit_cnt_r    <= '0;
         idle_cnt_r   <= '0;
         word_valid_r <= 1'b0;
      end else begin
         word_valid_r <= 1'b0;
         if (set_rise_s) begin
            shift_r    <= {shift_r[CMD_W-2:0], din_sync_r};
            idle_cnt_r <= '0;
            if (bit_cnt_r == BIT_LAST) begin
               bit_cnt_r    <= '0;
               word_valid_r <= 1'b1;
            end else begin
               bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
         end else if (timeout_s) begin
            bit_cnt_r  <= '0;
            idle_cnt_r <= '0;
         end else if (bit_cnt_r != '0) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
         end else begin
            idle_cnt_r <= '0;
         end
      end
   end

   assign act_s  = shift_r[ACT_BIT];
   assign mode_s = shift_r[MODE_BIT];
   assign chan_s = shift_r[CH_LSB +: CH_W];
   assign pos_s  = shift_r[POS_LSB +: POS_W];

   // Classify the completed word and build the one-hot channel select
   always_comb begin
      kind_s   = CMD_NONE;
      onehot_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(chan_s) == i) begin
            onehot_s[i] = 1'b1;
         end else begin
            onehot_s[i] = 1'b0;
         end
      end
      if (!word_valid_r) begin
         kind_s = CMD_NONE;
      end else if (int'(chan_s) >= N_CH) begin
         kind_s = CMD_BAD;
      end else if (!act_s) begin
         kind_s = CMD_CLEAR;
      end else if (mode_s == MODE_MAINT) begin
         kind_s = CMD_MAINT;
      end else begin
         kind_s = CMD_RUN;
      end
   end

   // Pending enables, target writes and mode for the decoded command
   always_comb begin
      pend_nxt_s  = pend_en_r;
      wr_en_s     = '0;
      maint_nxt_s = maint_mode_r;
      case (kind_s)
         CMD_CLEAR: begin
            pend_nxt_s = '0;
         end
         CMD_MAINT: begin
            pend_nxt_s  = onehot_s;
            wr_en_s     = onehot_s;
            maint_nxt_s = MODE_MAINT;
         end
         CMD_RUN: begin
            pend_nxt_s  = pend_en_r | onehot_s;
            wr_en_s     = onehot_s;
            maint_nxt_s = MODE_RUN;
         end
         default: begin
            pend_nxt_s  = pend_en_r;
            wr_en_s     = '0;
            maint_nxt_s = maint_mode_r;
         end
      endcase
   end

   // Command state and one-cycle status pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_en_r    <= '0;
         maint_mode_r <= 1'b0;
         cmd_ready_r  <= 1'b0;
         cmd_err_r    <= 1'b0;
      end else begin
         pend_en_r    <= pend_nxt_s;
         maint_mode_r <= maint_nxt_s;
         cmd_ready_r  <= (kind_s == CMD_CLEAR) || (kind_s == CMD_MAINT) || (kind_s == CMD_RUN);
         cmd_err_r    <= (kind_s == CMD_BAD) || timeout_s;
      end
   end

   assign boundary_s = (cnt_r == '0);

   // Shared PWM period counter and registered frame tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r        <= '0;
         frame_tick_r <= 1'b0;
      end else begin
         frame_tick_r <= boundary_s;
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      servo_pwm_channel #(
         .POS_W   (POS_W),
         .CNT_W   (CNT_W),
         .MIN_CYC (MIN_CYC),
         .STEP_CYC(STEP_CYC)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .boundary(boundary_s),
         .cnt     (cnt_r),
         .wr_en   (wr_en_s[g]),
         .wr_pos  (pos_s),
         .pend_en (pend_nxt_s[g]),
         .pulse   (pulse_s[g]),
         .en      (en_s[g])
      );
   end

   assign bus.servo_pulse = pulse_s;
   assign bus.chan_en     = en_s;
   assign bus.maint_mode  = maint_mode_r;
   assign bus.cmd_ready   = cmd_ready_r;
   assign bus.cmd_err     = cmd_err_r;
   assign bus.frame_tick  = frame_tick_r;

endmodule
